johnson_decoder_checker: RTL and testbench



---
 rtl/johnson_pkg.sv | 24 ++
 rtl/johnson_code_decode.sv | 39 +++
 rtl/johnson_decoder_checker.sv | 127 ++++++++++++
 tb/tb_johnson_decoder_checker.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/johnson_pkg.sv
// Shared definitions for Johnson-code sources and consumers: lock FSM
// states and the legal-code generator used by decoders and benches.
package johnson_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_e;

  // Legal code for phase k of an n-bit twisted ring: k ones filling from
  // the LSB for k <= n, then zeros filling from the LSB for k > n.
  function automatic logic [31:0] johnson_code(input int k, input int n);
    logic [31:0] full_mask;
    logic [31:0] low_mask;
    full_mask = (32'd1 << n) - 32'd1;
    if (k <= n) begin
      return (32'd1 << k) - 32'd1;
    end
    low_mask = (32'd1 << (k - n)) - 32'd1;
    return full_mask & ~low_mask;
  endfunction

endpackage

// File: rtl/johnson_code_decode.sv
// Combinational Johnson-code matcher: compares the sample against every
// legal code and reports legality, binary phase index and one-hot phase.
module johnson_code_decode
  import johnson_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = $clog2(2 * N)
) (
  input  logic [N-1:0]   jc_in,
  output logic           legal,
  output logic [IW-1:0]  idx,
  output logic [2*N-1:0] onehot
);

  logic [2*N-1:0] match;

  genvar gi;
  generate
    for (gi = 0; gi < 2 * N; gi++) begin : g_code
      localparam logic [31:0] CODE = johnson_code(gi, N);
      assign match[gi] = (jc_in == CODE[N-1:0]);
    end
  endgenerate

  // Legal codes are distinct, so at most one match bit is ever set; the
  // match vector is already the one-hot phase and an OR-reduce gives idx.
  always_comb begin
    idx = '0;
    for (int k = 0; k < 2 * N; k++) begin
      if (match[k]) begin
        idx = idx | IW'(k);
      end
    end
  end

  assign onehot = match;
  assign legal  = |match;

endmodule

// File: rtl/johnson_decoder_checker.sv
// Receive-side Johnson decoder: registers the decoded phase, flags illegal
// codes and tracks +1 sequence continuity with an IDLE/TRACK/LOCKED FSM.
module johnson_decoder_checker
  import johnson_pkg::*;
#(
  parameter int N        = 4,
  parameter int LOCK_CNT = 4,
  localparam int IW      = $clog2(2 * N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   jc_in,
  input  logic           in_valid,
  output logic [IW-1:0]  idx_out,
  output logic [2*N-1:0] onehot_out,
  output logic           out_valid,
  output logic           illegal,
  output logic           seq_err,
  output logic           locked,
  output logic [7:0]     err_count
);

  // Run counter must reach LOCK_CNT+1 (at most 2N+1).
  localparam int RW = $clog2(2 * N + 2);
  localparam logic [RW-1:0] LOCK_RUN = RW'(LOCK_CNT + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(2 * N - 1);

  logic           dec_legal;
  logic [IW-1:0]  dec_idx;
  logic [2*N-1:0] dec_onehot;

  state_e         state_reg;
  logic [RW-1:0]  run_reg;
  logic [IW-1:0]  prev_reg;

  logic [IW-1:0]  prev_succ;
  logic           good_step;
  logic           seq_err_set;

  johnson_code_decode #(.N(N)) u_decode (
    .jc_in  (jc_in),
    .legal  (dec_legal),
    .idx    (dec_idx),
    .onehot (dec_onehot)
  );

  // Expected successor of the last legal phase, wrapping 2N-1 -> 0; any
  // continuity break on a valid sample while locked raises seq_err.
  always_comb begin
    prev_succ   = (prev_reg == LAST_IDX) ? '0 : prev_reg + 1'b1;
    good_step   = dec_legal && (dec_idx == prev_succ);
    seq_err_set = in_valid && (state_reg == LOCKED) && !good_step;
  end

  // Registered decode outputs plus lock FSM; invalid cycles leave the
  // phase outputs, FSM, run counter and previous index untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_out    <= '0;
      onehot_out <= '0;
      out_valid  <= 1'b0;
      illegal    <= 1'b0;
      seq_err    <= 1'b0;
      locked     <= 1'b0;
      state_reg  <= IDLE;
      run_reg    <= '0;
      prev_reg   <= '0;
    end else begin
      out_valid <= in_valid;
      illegal   <= in_valid && !dec_legal;
      seq_err   <= seq_err_set;
      if (in_valid) begin
        if (!dec_legal) begin
          idx_out    <= '0;
          onehot_out <= '0;
          state_reg  <= IDLE;
          run_reg    <= '0;
          locked     <= 1'b0;
        end else begin
          idx_out    <= dec_idx;
          onehot_out <= dec_onehot;
          prev_reg   <= dec_idx;
          unique case (state_reg)
            IDLE: begin
              state_reg <= TRACK;
              run_reg   <= RW'(1);
              locked    <= 1'b0;
            end
            TRACK: begin
              if (good_step) begin
                run_reg <= run_reg + 1'b1;
                if (run_reg + 1'b1 == LOCK_RUN) begin
                  state_reg <= LOCKED;
                  locked    <= 1'b1;
                end
              end else begin
                run_reg <= RW'(1);
              end
            end
            LOCKED: begin
              if (!good_step) begin
                state_reg <= TRACK;
                run_reg   <= RW'(1);
                locked    <= 1'b0;
              end
            end
            default: begin
              state_reg <= IDLE;
              run_reg   <= '0;
              locked    <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  // Saturating count of continuity errors; only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_count <= 8'd0;
    end else if (seq_err_set && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_johnson_decoder_checker.sv
// Self-checking bench for johnson_decoder_checker: directed scenarios plus
// randomized traffic against a phase-level reference model.
module tb_johnson_decoder_checker;

  localparam int N        = 4;
  localparam int LOCK_CNT = 4;
  localparam int S        = 2 * N;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] jc_in;
  logic       in_valid;
  logic [2:0] idx_out;
  logic [7:0] onehot_out;
  logic       out_valid;
  logic       illegal;
  logic       seq_err;
  logic       locked;
  logic [7:0] err_count;

  int checks   = 0;
  int failures = 0;

  // reference model state
  int         m_mode;    // 0 idle, 1 tracking, 2 locked
  int         m_run;
  int         m_prev;
  int         m_errs;
  logic [2:0] exp_idx;
  logic [7:0] exp_oh;
  logic       exp_valid;
  logic       exp_illegal;
  logic       exp_seqerr;
  int         nxt;

  johnson_decoder_checker #(.N(N), .LOCK_CNT(LOCK_CNT)) dut (
    .clk        (clk),
    .reset      (reset),
    .jc_in      (jc_in),
    .in_valid   (in_valid),
    .idx_out    (idx_out),
    .onehot_out (onehot_out),
    .out_valid  (out_valid),
    .illegal    (illegal),
    .seq_err    (seq_err),
    .locked     (locked),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  wire [22:0] obs = {idx_out, onehot_out, out_valid, illegal, seq_err, locked, err_count};

  function automatic int code_of(input int k);
    if (k <= N) return (1 << k) - 1;
    return ((1 << N) - 1) & ~((1 << (k - N)) - 1);
  endfunction

  function automatic int find_idx(input int c);
    for (int k = 0; k < S; k++) if (code_of(k) == c) return k;
    return -1;
  endfunction

  function automatic logic [22:0] exp_vec();
    logic [7:0] e;
    e = 8'(m_errs);
    return {exp_idx, exp_oh, exp_valid, exp_illegal, exp_seqerr, (m_mode == 2), e};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_run = 0; m_prev = 0; m_errs = 0;
    exp_idx = '0; exp_oh = '0; exp_valid = 0; exp_illegal = 0; exp_seqerr = 0;
  endtask

  // Applies one sample for one clock and advances the model by the rules.
  task automatic drive(input int code, input bit v);
    int k;
    bit good;
    @(negedge clk);
    jc_in = 4'(code);
    in_valid = v;
    @(posedge clk);
    #1;
    exp_valid = v; exp_illegal = 0; exp_seqerr = 0;
    if (v) begin
      k = find_idx(code);
      if (k < 0) begin
        exp_idx = 0; exp_oh = 0; exp_illegal = 1;
        if (m_mode == 2) exp_seqerr = 1;
        m_mode = 0; m_run = 0;
      end else begin
        exp_idx = 3'(k); exp_oh = '0; exp_oh[k] = 1'b1;
        good = (k == (m_prev + 1) % S);
        if (m_mode == 0) begin
          m_mode = 1; m_run = 1;
        end else if (m_mode == 1) begin
          if (good) begin
            m_run++;
            if (m_run == LOCK_CNT + 1) m_mode = 2;
          end else m_run = 1;
        end else if (!good) begin
          m_mode = 1; m_run = 1; exp_seqerr = 1;
        end
        m_prev = k;
        nxt = (k + 1) % S;
      end
      if (exp_seqerr && m_errs < 255) m_errs++;
    end
  endtask

  task automatic test_reset();
    reset = 1; jc_in = 0; in_valid = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 0;
    #1;
    checks++;
    if (obs !== 23'd0) begin
      failures++;
      $display("FAIL reset_state got=%h exp=%h", obs, 23'd0);
    end
  endtask

  task automatic test_lock_sequence();
    for (int i = 0; i < 9; i++) begin
      drive(code_of(i % S), 1);
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL lock_seq[%0d] got=%h exp=%h", i, obs, exp_vec());
      end
      checks++;
      if (locked !== (i >= 4)) begin
        failures++;
        $display("FAIL lock_timing[%0d] got=%b exp=%b", i, locked, (i >= 4));
      end
    end
  endtask

  task automatic test_illegal_inject();
    drive(4'b0101, 1);
    checks++;
    if ({illegal, seq_err, idx_out, onehot_out, locked} !== {1'b1, 1'b1, 3'd0, 8'd0, 1'b0}) begin
      failures++;
      $display("FAIL illegal_inject got=%b%b %h %h %b exp=11 0 00 0",
               illegal, seq_err, idx_out, onehot_out, locked);
    end
    for (int i = 0; i < 5; i++) begin
      drive(code_of(i), 1);
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL illegal_relock[%0d] got=%h exp=%h", i, obs, exp_vec());
      end
    end
    checks++;
    if ({locked, err_count} !== {1'b1, 8'd1}) begin
      failures++;
      $display("FAIL illegal_relock_final got=%b/%0d exp=1/1", locked, err_count);
    end
  endtask

  task automatic test_skip();
    // continue from idx 4 round to idx 3 while locked, then jump to 5
    for (int i = 5; i < 12; i++) drive(code_of(i % S), 1);
    drive(code_of(5), 1);
    checks++;
    if ({seq_err, illegal, idx_out, locked} !== {1'b1, 1'b0, 3'd5, 1'b0} || obs !== exp_vec()) begin
      failures++;
      $display("FAIL skip got=%h exp=%h", obs, exp_vec());
    end
    for (int i = 6; i < 10; i++) begin
      drive(code_of(i % S), 1);
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL skip_relock[%0d] got=%h exp=%h", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_gap();
    logic [22:0] held;
    drive(code_of(nxt), 1);
    held = obs;
    for (int i = 0; i < 3; i++) begin
      drive(int'($urandom_range(0, 15)), 0);
      checks++;
      if (obs !== exp_vec() || idx_out !== held[22:20] || locked !== 1'b1) begin
        failures++;
        $display("FAIL gap[%0d] got=%h exp=%h", i, obs, exp_vec());
      end
    end
    drive(code_of(nxt), 1);
    checks++;
    if (obs !== exp_vec() || seq_err !== 1'b0) begin
      failures++;
      $display("FAIL gap_resume got=%h exp=%h", obs, exp_vec());
    end
  endtask

  task automatic test_saturation();
    for (int e = 0; e < 260; e++) begin
      drive(code_of((nxt + 1) % S), 1);
      for (int j = 0; j < LOCK_CNT; j++) drive(code_of(nxt), 1);
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL saturation[%0d] got=%h exp=%h", e, obs, exp_vec());
      end
    end
    checks++;
    if (err_count !== 8'd255) begin
      failures++;
      $display("FAIL err_saturate got=%0d exp=255", err_count);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    #2;
    reset = 1;
    #1;
    checks++;
    if (obs !== 23'd0) begin
      failures++;
      $display("FAIL async_reset got=%h exp=%h", obs, 23'd0);
    end
    model_reset();
    @(negedge clk);
    reset = 0;
    drive(4'b0011, 1);
    checks++;
    if ({idx_out, locked, out_valid} !== {3'd2, 1'b0, 1'b1} || obs !== exp_vec()) begin
      failures++;
      $display("FAIL post_reset got=%h exp=%h", obs, exp_vec());
    end
  endtask

  task automatic test_random();
    int r;
    int c;
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 70) drive(code_of(nxt), 1);
      else if (r < 80) drive(code_of(int'($urandom_range(0, S - 1))), 1);
      else if (r < 88) begin
        c = int'($urandom_range(0, 15));
        while (find_idx(c) >= 0) c = int'($urandom_range(0, 15));
        drive(c, 1);
      end else drive(int'($urandom_range(0, 15)), 0);
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL random[%0d] got=%h exp=%h", i, obs, exp_vec());
      end
    end
  endtask

  initial begin
    nxt = 0;
    test_reset();
    test_lock_sequence();
    test_illegal_inject();
    test_skip();
    test_gap();
    test_saturation();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
